traffic_countdown_display: RTL and testbench

//  Display-side consumer of the traffic controller outputs: takes the 8-bit countdown and
//  the 6-bit lamp vector. Drives a 3-digit multiplexed 7-segment countdown display and

---
 rtl/traffic_countdown_display.sv | 197 +++++++++++++++++++
 tb/tb_traffic_countdown_display.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/traffic_countdown_display.sv
`default_nettype none
// ============================================================================
// Module      : traffic_countdown_display
// Description : Display-side consumer of the traffic controller. Converts the
//               8-bit countdown to BCD serially (shift-add-3, one bit per
//               clock), scans it onto a 3-digit multiplexed 7-segment display
//               with leading-zero blanking and lamp test, and registers the
//               lamp vector onto the LED pins.
// Revision    : 1.0 - initial release
// ============================================================================
module traffic_countdown_display #(
    parameter int SCAN_DIV = 1000
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [7:0] count,
    input  logic [5:0] light,
    output logic [6:0] seg,
    output logic [2:0] an,
    output logic [5:0] led
);

    // Converter FSM encoding
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam int             DIV_W      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [5:0]     C_LAMP_ALL = 6'b111111;

    // Converter state
    logic [1:0]  state_q, state_d;
    logic [19:0] sh_q, sh_d;
    logic [3:0]  bitcnt_q, bitcnt_d;
    logic [7:0]  last_q, last_d;
    logic [11:0] bcd_q, bcd_d;
    logic [19:0] w_adj;

    // Scan state
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       idx_q, idx_d;

    // Output registers
    logic [6:0] seg_q, seg_d;
    logic [2:0] an_q, an_d;
    logic [5:0] led_q;

    logic [3:0] w_digit;
    logic       w_blank;

    // 7-segment decode {g,f,e,d,c,b,a}; out-of-range nibbles go dark
    function automatic logic [6:0] f_decode(input logic [3:0] d);
        logic [6:0] r;
        case (d)
            4'd0:    r = 7'h3F;
            4'd1:    r = 7'h06;
            4'd2:    r = 7'h5B;
            4'd3:    r = 7'h4F;
            4'd4:    r = 7'h66;
            4'd5:    r = 7'h6D;
            4'd6:    r = 7'h7D;
            4'd7:    r = 7'h07;
            4'd8:    r = 7'h7F;
            4'd9:    r = 7'h6F;
            default: r = 7'h00;
        endcase
        return r;
    endfunction

    // Add-3 correction on each BCD nibble that is 5 or more, ahead of the shift
    always_comb begin
        w_adj = sh_q;
        if (sh_q[11:8]  >= 4'd5) w_adj[11:8]  = sh_q[11:8]  + 4'd3;
        if (sh_q[15:12] >= 4'd5) w_adj[15:12] = sh_q[15:12] + 4'd3;
        if (sh_q[19:16] >= 4'd5) w_adj[19:16] = sh_q[19:16] + 4'd3;
    end

    // Converter next-state: latch a new count, shift 8 times, then publish
    always_comb begin
        state_d  = state_q;
        sh_d     = sh_q;
        bitcnt_d = bitcnt_q;
        last_d   = last_q;
        bcd_d    = bcd_q;
        case (state_q)
            S_IDLE: begin
                // Re-checked on every return to IDLE, so the latest count wins
                if (count != last_q) begin
                    last_d   = count;
                    sh_d     = {12'b0, count};
                    bitcnt_d = 4'd0;
                    state_d  = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (bitcnt_q == 4'd8) begin
                    state_d = S_DONE;
                end else begin
                    sh_d     = w_adj << 1;
                    bitcnt_d = bitcnt_q + 4'd1;
                end
            end
            S_DONE: begin
                bcd_d   = sh_q[19:8];
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Scan divider and digit index: each index held for SCAN_DIV cycles
    always_comb begin
        div_d = div_q + 1'b1;
        idx_d = idx_q;
        if (div_q == C_DIV_LAST) begin
            div_d = '0;
            idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
        end
    end

    // Digit selection, leading-zero blanking and lamp-test override
    always_comb begin
        w_digit = 4'd0;
        w_blank = 1'b1;
        an_d    = 3'b111;
        case (idx_q)
            2'd0: begin
                w_digit = bcd_q[3:0];
                w_blank = (bcd_q == 12'h000);
                an_d    = 3'b110;
            end
            2'd1: begin
                w_digit = bcd_q[7:4];
                w_blank = (bcd_q[11:8] == 4'd0) && (bcd_q[7:4] == 4'd0);
                an_d    = 3'b101;
            end
            2'd2: begin
                w_digit = bcd_q[11:8];
                w_blank = (bcd_q[11:8] == 4'd0);
                an_d    = 3'b011;
            end
            default: begin
                w_digit = 4'd0;
                w_blank = 1'b1;
                an_d    = 3'b111;
            end
        endcase
        if (light == C_LAMP_ALL) begin
            seg_d = 7'h7F;
        end else if (w_blank) begin
            seg_d = 7'h00;
        end else begin
            seg_d = f_decode(w_digit);
        end
    end

    // Converter registers; reset aborts any conversion in flight
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q  <= S_IDLE;
            sh_q     <= 20'd0;
            bitcnt_q <= 4'd0;
            last_q   <= 8'd0;
            bcd_q    <= 12'h000;
        end else begin
            state_q  <= state_d;
            sh_q     <= sh_d;
            bitcnt_q <= bitcnt_d;
            last_q   <= last_d;
            bcd_q    <= bcd_d;
        end
    end

    // Scan registers and registered pin outputs
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            div_q <= '0;
            idx_q <= 2'd0;
            seg_q <= 7'h00;
            an_q  <= 3'b111;
            led_q <= 6'd0;
        end else begin
            div_q <= div_d;
            idx_q <= idx_d;
            seg_q <= seg_d;
            an_q  <= an_d;
            led_q <= light;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;
    assign led = led_q;

endmodule
`default_nettype wire

// File: tb/tb_traffic_countdown_display.sv
`default_nettype none
// ============================================================================
// Module      : tb_traffic_countdown_display
// Description : Directed self-checking bench for traffic_countdown_display
//               with a short scan period.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_traffic_countdown_display;

    localparam int SCAN_DIV = 4;

    logic       clk;
    logic       clr;
    logic [7:0] count;
    logic [5:0] light;
    logic [6:0] seg;
    logic [2:0] an;
    logic [5:0] led;

    int checks;
    int errors;

    traffic_countdown_display #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk   (clk),
        .clr   (clr),
        .count (count),
        .light (light),
        .seg   (seg),
        .an    (an),
        .led   (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Observe one full scan frame; return last seg seen per slot and slot lengths
    task automatic capture_frame(output logic [6:0] su, output logic [6:0] st,
                                 output logic [6:0] shd, output int nu,
                                 output int nt, output int nh);
        su = 7'h55; st = 7'h55; shd = 7'h55;
        nu = 0; nt = 0; nh = 0;
        for (int i = 0; i < 3 * SCAN_DIV; i++) begin
            @(negedge clk);
            case (an)
                3'b110: begin su  = seg; nu++; end
                3'b101: begin st  = seg; nt++; end
                3'b011: begin shd = seg; nh++; end
                default: ;
            endcase
        end
    endtask

    task automatic test_reset();
        clr = 1'b0; count = 8'd37; light = 6'h21;
        wait_cycles(3);
        checks++;
        if (seg !== 7'h00) begin errors++; $display("FAIL reset_seg: got %h want 00", seg); end
        checks++;
        if (an !== 3'b111) begin errors++; $display("FAIL reset_an: got %b want 111", an); end
        checks++;
        if (led !== 6'h00) begin errors++; $display("FAIL reset_led: got %h want 00", led); end
    endtask

    task automatic test_count15();
        logic [6:0] su, st, shd; int nu, nt, nh;
        count = 8'd15;
        clr = 1'b1;
        wait_cycles(20);
        checks++;
        if (led !== 6'h21) begin errors++; $display("FAIL led_copy: got %h want 21", led); end
        capture_frame(su, st, shd, nu, nt, nh);
        checks++;
        if (su !== 7'h6D) begin errors++; $display("FAIL c15_units: got %h want 6D", su); end
        checks++;
        if (st !== 7'h06) begin errors++; $display("FAIL c15_tens: got %h want 06", st); end
        checks++;
        if (shd !== 7'h00) begin errors++; $display("FAIL c15_hund: got %h want 00", shd); end
        checks++;
        if (nu !== SCAN_DIV || nt !== SCAN_DIV || nh !== SCAN_DIV) begin
            errors++;
            $display("FAIL slot_len: got %0d/%0d/%0d want %0d each", nu, nt, nh, SCAN_DIV);
        end
    endtask

    task automatic test_values();
        logic [6:0] su, st, shd; int nu, nt, nh;
        count = 8'd255;
        wait_cycles(20);
        capture_frame(su, st, shd, nu, nt, nh);
        checks++;
        if ({shd, st, su} !== {7'h5B, 7'h6D, 7'h6D}) begin
            errors++; $display("FAIL c255: got %h %h %h want 5B 6D 6D", shd, st, su);
        end
        count = 8'd105;
        wait_cycles(20);
        capture_frame(su, st, shd, nu, nt, nh);
        checks++;
        if ({shd, st, su} !== {7'h06, 7'h3F, 7'h6D}) begin
            errors++; $display("FAIL c105: got %h %h %h want 06 3F 6D", shd, st, su);
        end
        count = 8'd10;
        wait_cycles(20);
        capture_frame(su, st, shd, nu, nt, nh);
        checks++;
        if ({shd, st, su} !== {7'h00, 7'h06, 7'h3F}) begin
            errors++; $display("FAIL c10: got %h %h %h want 00 06 3F", shd, st, su);
        end
        count = 8'd0;
        wait_cycles(20);
        capture_frame(su, st, shd, nu, nt, nh);
        checks++;
        if ({shd, st, su} !== {7'h00, 7'h00, 7'h00}) begin
            errors++; $display("FAIL c0_blank: got %h %h %h want 00 00 00", shd, st, su);
        end
    endtask

    task automatic test_latest_wins();
        logic [6:0] su, st, shd; int nu, nt, nh;
        logic [6:0] first_units;
        logic       seen;
        first_units = 7'h00;
        seen = 1'b0;
        count = 8'd15;
        wait_cycles(3);
        count = 8'd14;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!seen && an == 3'b110 && seg != 7'h00) begin
                first_units = seg;
                seen = 1'b1;
            end
        end
        checks++;
        if (first_units !== 7'h6D) begin
            errors++; $display("FAIL first_value: got units %h want 6D", first_units);
        end
        capture_frame(su, st, shd, nu, nt, nh);
        checks++;
        if ({shd, st, su} !== {7'h00, 7'h06, 7'h66}) begin
            errors++; $display("FAIL c14_final: got %h %h %h want 00 06 66", shd, st, su);
        end
        wait_cycles(12);
        capture_frame(su, st, shd, nu, nt, nh);
        checks++;
        if ({shd, st, su} !== {7'h00, 7'h06, 7'h66}) begin
            errors++; $display("FAIL c14_stable: got %h %h %h want 00 06 66", shd, st, su);
        end
    endtask

    task automatic test_lamp();
        logic [6:0] su, st, shd; int nu, nt, nh;
        count = 8'd0;
        wait_cycles(20);
        light = 6'b111111;
        @(negedge clk);
        checks++;
        if (led !== 6'h3F) begin errors++; $display("FAIL lamp_led: got %h want 3F", led); end
        capture_frame(su, st, shd, nu, nt, nh);
        checks++;
        if ({shd, st, su} !== {7'h7F, 7'h7F, 7'h7F}) begin
            errors++; $display("FAIL lamp_seg: got %h %h %h want 7F 7F 7F", shd, st, su);
        end
        light = 6'h21;
        wait_cycles(2);
        capture_frame(su, st, shd, nu, nt, nh);
        checks++;
        if ({shd, st, su} !== {7'h00, 7'h00, 7'h00}) begin
            errors++; $display("FAIL lamp_off: got %h %h %h want 00 00 00", shd, st, su);
        end
    endtask

    task automatic test_reset_mid();
        logic [6:0] su, st, shd; int nu, nt, nh;
        count = 8'd200;
        wait_cycles(4);
        clr = 1'b0;
        count = 8'd5;
        #1;
        checks++;
        if ({seg, an, led} !== {7'h00, 3'b111, 6'h00}) begin
            errors++; $display("FAIL mid_reset: got seg %h an %b led %h want 00 111 00", seg, an, led);
        end
        wait_cycles(2);
        clr = 1'b1;
        wait_cycles(20);
        capture_frame(su, st, shd, nu, nt, nh);
        checks++;
        if ({shd, st, su} !== {7'h00, 7'h00, 7'h6D}) begin
            errors++; $display("FAIL after_reset5: got %h %h %h want 00 00 6D", shd, st, su);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clr = 1'b0;
        count = 8'd0;
        light = 6'd0;
        test_reset();
        test_count15();
        test_values();
        test_latest_wins();
        test_lamp();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
